// File: rtl/img_stream_src.sv
// Raster pixel transmitter: ready/valid in, valid-only tagged stream out,
// followed by constant-valued flush rows that drain the downstream row delays.
module img_stream_src #(
   parameter int unsigned IMG_WIDTH   = 8,
   parameter int unsigned DIM_WIDTH   = 12,
   parameter int unsigned FLUSH_WIDTH = 4,
   parameter logic [IMG_WIDTH-1:0] FLUSH_VALUE = {IMG_WIDTH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIM_WIDTH-1:0]   cfg_width,
   input  logic [DIM_WIDTH-1:0]   cfg_height,
   input  logic [FLUSH_WIDTH-1:0] cfg_flush,
   input  logic                   cfg_set,
   input  logic [IMG_WIDTH-1:0]   up_data,
   input  logic                   up_val,
   output logic                   up_rdy,
   output logic [IMG_WIDTH-1:0]   dn_data,
   output logic                   dn_val,
   output logic                   dn_sol,
   output logic                   dn_eol,
   output logic                   dn_eof,
   output logic                   busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [DIM_WIDTH-1:0]   col_q, col_d;
   logic [DIM_WIDTH-1:0]   row_q, row_d;
   logic [DIM_WIDTH-1:0]   w_q, w_d;
   logic [DIM_WIDTH-1:0]   h_q, h_d;
   logic [FLUSH_WIDTH-1:0] f_q, f_d;
   logic [IMG_WIDTH-1:0]   dn_data_q, dn_data_d;
   logic                   dn_val_q, dn_val_d;
   logic                   dn_sol_q, dn_sol_d;
   logic                   dn_eol_q, dn_eol_d;
   logic                   dn_eof_q, dn_eof_d;

   logic                   xfer_s;
   logic                   col_last_s;
   logic                   cfg_ok_s;
   logic [DIM_WIDTH-1:0]   w_m1_s, h_m1_s, f_m1_s;

   assign up_rdy     = (state_q == ACTIVE);
   assign busy       = (state_q != IDLE);
   assign xfer_s     = up_val & up_rdy;
   assign cfg_ok_s   = cfg_set && (cfg_width != {DIM_WIDTH{1'b0}}) && (cfg_height != {DIM_WIDTH{1'b0}});
   assign w_m1_s     = w_q - DIM_WIDTH'(1);
   assign h_m1_s     = h_q - DIM_WIDTH'(1);
   assign f_m1_s     = DIM_WIDTH'(f_q) - DIM_WIDTH'(1);
   assign col_last_s = (col_q == w_m1_s);

   // Next-state, raster counters and output register contents.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      w_d       = w_q;
      h_d       = h_q;
      f_d       = f_q;
      dn_data_d = dn_data_q;
      dn_val_d  = 1'b0;
      dn_sol_d  = 1'b0;
      dn_eol_d  = 1'b0;
      dn_eof_d  = 1'b0;

      case (state_q)
         ACTIVE: begin
            if (xfer_s) begin
               dn_data_d = up_data;
               dn_val_d  = 1'b1;
               dn_sol_d  = (col_q == {DIM_WIDTH{1'b0}});
               dn_eol_d  = col_last_s;
               dn_eof_d  = col_last_s && (row_q == h_m1_s) && (f_q == {FLUSH_WIDTH{1'b0}});
               if (col_last_s) begin
                  col_d = {DIM_WIDTH{1'b0}};
                  if (row_q == h_m1_s) begin
                     row_d   = {DIM_WIDTH{1'b0}};
                     state_d = (f_q != {FLUSH_WIDTH{1'b0}}) ? FLUSH : IDLE;
                  end else begin
                     row_d = row_q + DIM_WIDTH'(1);
                  end
               end else begin
                  col_d = col_q + DIM_WIDTH'(1);
               end
            end else begin
               dn_val_d = 1'b0;
            end
         end
         FLUSH: begin
            dn_data_d = FLUSH_VALUE;
            dn_val_d  = 1'b1;
            dn_sol_d  = (col_q == {DIM_WIDTH{1'b0}});
            dn_eol_d  = col_last_s;
            dn_eof_d  = col_last_s && (row_q == f_m1_s);
            if (col_last_s) begin
               col_d = {DIM_WIDTH{1'b0}};
               if (row_q == f_m1_s) begin
                  row_d   = {DIM_WIDTH{1'b0}};
                  state_d = IDLE;
               end else begin
                  row_d = row_q + DIM_WIDTH'(1);
               end
            end else begin
               col_d = col_q + DIM_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A valid config restarts the frame and drops whatever this cycle produced.
      if (cfg_ok_s) begin
         w_d      = cfg_width;
         h_d      = cfg_height;
         f_d      = cfg_flush;
         col_d    = {DIM_WIDTH{1'b0}};
         row_d    = {DIM_WIDTH{1'b0}};
         state_d  = ACTIVE;
         dn_val_d = 1'b0;
         dn_sol_d = 1'b0;
         dn_eol_d = 1'b0;
         dn_eof_d = 1'b0;
      end else begin
         w_d = w_q;
      end
   end

   // State, counters, config and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         col_q     <= {DIM_WIDTH{1'b0}};
         row_q     <= {DIM_WIDTH{1'b0}};
         w_q       <= {DIM_WIDTH{1'b0}};
         h_q       <= {DIM_WIDTH{1'b0}};
         f_q       <= {FLUSH_WIDTH{1'b0}};
         dn_data_q <= {IMG_WIDTH{1'b0}};
         dn_val_q  <= 1'b0;
         dn_sol_q  <= 1'b0;
         dn_eol_q  <= 1'b0;
         dn_eof_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         w_q       <= w_d;
         h_q       <= h_d;
         f_q       <= f_d;
         dn_data_q <= dn_data_d;
         dn_val_q  <= dn_val_d;
         dn_sol_q  <= dn_sol_d;
         dn_eol_q  <= dn_eol_d;
         dn_eof_q  <= dn_eof_d;
      end
   end

   assign dn_data = dn_data_q;
   assign dn_val  = dn_val_q;
   assign dn_sol  = dn_sol_q;
   assign dn_eol  = dn_eol_q;
   assign dn_eof  = dn_eof_q;

endmodule

// File: doc/img_stream_src.md
Name: img_stream_src

Overview:
Image-stream transmitter that sits upstream of the row-delay memories and the filter. It accepts raster pixels from a ready/valid producer and re-emits them on the valid-only stream that the delay lines and filter consume, adding start-of-row, end-of-row and end-of-frame tags. After the last real row it injects a configurable number of constant-valued flush rows so the delay lines drain the final rows through the filter.

Parameters:
IMG_WIDTH, 8, pixel width in bits
DIM_WIDTH, 12, width of row/column counters and dimension config
FLUSH_WIDTH, 4, width of flush-row count config
FLUSH_VALUE, 0, pixel value emitted during flush rows (IMG_WIDTH bits)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cfg_width  input  DIM_WIDTH  pixels per row (W)
cfg_height  input  DIM_WIDTH  rows per frame (H)
cfg_flush  input  FLUSH_WIDTH  flush rows after frame (F)
cfg_set  input  1  load config and start a frame
up_data  input  IMG_WIDTH  incoming pixel
up_val  input  1  incoming pixel valid
up_rdy  output  1  block accepts pixel this cycle
dn_data  output  IMG_WIDTH  outgoing pixel
dn_val  output  1  outgoing pixel valid, single-cycle qualifier
dn_sol  output  1  first pixel of a row (valid with dn_val)
dn_eol  output  1  last pixel of a row (valid with dn_val)
dn_eof  output  1  last pixel of the whole emission, including flush (valid with dn_val)
busy  output  1  state != IDLE

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high. On rst: state=IDLE, col=0, row=0, config registers=0, dn_data=0, dn_val=0, dn_sol=0, dn_eol=0, dn_eof=0. up_rdy=0 and busy=0 follow from IDLE.
- States: IDLE, ACTIVE, FLUSH.
- up_rdy = (state==ACTIVE). It is combinational from state only, never from up_val.
- A transfer occurs when up_val & up_rdy.
- cfg_set, any state:
  - If cfg_width!=0 and cfg_height!=0: on that edge, latch W/H/F, set col=0, row=0, state=ACTIVE.
  - Otherwise cfg_set is ignored and state and config are unchanged.
  - cfg_set has priority over any transfer or flush in the same cycle. An in-flight frame is aborted with no eof. The output register still updates for that cycle's transfer (the pixel is dropped), so dn_val=0 the next cycle.
- ACTIVE: on each transfer, the pixel is registered to dn_data with dn_val=1 on the next cycle. Latency is exactly 1 cycle and order is preserved.
  - Tags: dn_sol = (col==0); dn_eol = (col==W-1); dn_eof = (col==W-1 && row==H-1 && F==0).
  - col increments, wrapping to 0 at W-1; row increments on col wrap.
  - On the last pixel (col==W-1, row==H-1): col=0, row=0, and state becomes FLUSH if F!=0, else IDLE.
  - Cycles without a transfer give dn_val=0. dn_data holds its last value.
- FLUSH: emit FLUSH_VALUE with dn_val=1 every cycle, back-to-back, for F*W pixels total.
  - Same col/row counting (row counts flush rows, 0..F-1) and same sol/eol tags.
  - dn_eof on col==W-1 && row==F-1; after that pixel, state=IDLE.
  - up_rdy=0 throughout FLUSH.
- IDLE: dn_val=0 every cycle. Config registers are retained.
- dn_sol/dn_eol/dn_eof are 0 whenever dn_val=0.
- W==1: dn_sol and dn_eol are both asserted on every pixel.
- Counter arithmetic is DIM_WIDTH bits. Comparisons are against W-1, H-1, F-1 computed in the same width; these never underflow because zero dims are rejected and F is checked against 0 first.
- rst mid-frame or mid-flush: immediate return to reset values with no further dn_val.

Test Plan:
- W=4,H=2,F=1, cfg_set, then up_val held with pixels 1..8 -> dn_data 1..8 on consecutive cycles, 1 cycle after each transfer. sol on 1,5,9; eol on 4,8,12. Then four FLUSH_VALUE=0 pixels back-to-back, eof only on the 12th output. Then busy=0 and up_rdy=0.
- W=3,H=1,F=0, pixels A,B,C with up_val gaps of 2 cycles -> three outputs each 1 cycle after its transfer, dn_val=0 in gaps, eol+eof on C, state IDLE immediately after.
- cfg_set with cfg_width=0 (or cfg_height=0) while IDLE -> state stays IDLE, up_rdy stays 0. Same while ACTIVE -> frame continues unaffected.
- W=4,H=2 frame, 5 pixels sent, then cfg_set with W=2,H=1,F=0 coincident with a 6th up_val -> 6th pixel dropped (dn_val=0 next cycle). Next pixel out has sol=1. Two pixels complete the new frame with eof.
- Assert rst asynchronously (mid-cycle) during the FLUSH of W=4,H=1,F=2 after 3 flush pixels -> dn_val falls without waiting for a clock edge, busy=0, no eof observed. A fresh cfg_set then runs normally.
- W=1,H=3,F=1 -> every output has sol=eol=1. Four outputs total, eof only on the flush pixel.
